// File: rtl/rot_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// rot_arbiter_pkg
//   Shared definitions for the rotation-datapath scheduler:
//   - arb_state_t : scheduler state encoding (RUN / DRAIN / PAUSED)
//   - clog2_int   : constant-friendly ceiling log2
//   - word_num    : number of words on the datapath bus
// ---------------------------------------------------------------------------
package rot_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_RUN    = 2'd0,
      ST_DRAIN  = 2'd1,
      ST_PAUSED = 2'd2
   } arb_state_t;

   function automatic int clog2_int(input int value);
      int result;
      result = 0;
      while ((1 << result) < value) result++;
      return result;
   endfunction

   function automatic int word_num(input int bus_size, input int word_size);
      return bus_size / word_size;
   endfunction

endpackage

// File: rtl/rot_arbiter_rr_arb2.sv
// ---------------------------------------------------------------------------
// rr_arb2
//   Two-way round-robin arbiter. The pointer names the requester that wins
//   when both request; after any grant it moves to the other requester.
// Ports:
//   clk, reset : clock and synchronous active-high reset (pointer -> 0)
//   en         : arbitration enable; no grant is issued while low
//   req[1:0]   : request vector, bit N = requester N
//   grant[1:0] : one-hot grant, only set for a requesting bit
// ---------------------------------------------------------------------------
module rr_arb2 (
   input  logic       clk,
   input  logic       reset,
   input  logic       en,
   input  logic [1:0] req,
   output logic [1:0] grant
);

   logic ptr_reg;
   logic ptr_next;

   always_comb begin
      grant    = 2'b00;
      ptr_next = ptr_reg;
      if (en) begin
         case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = ptr_reg ? 2'b10 : 2'b01;
            default: grant = 2'b00;
         endcase
      end
      if (grant[0]) begin
         ptr_next = 1'b1;
      end else if (grant[1]) begin
         ptr_next = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ptr_reg <= 1'b0;
      end else begin
         ptr_reg <= ptr_next;
      end
   end

endmodule

// File: rtl/rot_arbiter.sv
// ---------------------------------------------------------------------------
// rot_arbiter
//   Shares one pipelined word-rotation datapath between two requesters.
//   Grants round-robin (one issue per cycle), tags each issue with the
//   requester id and routes the result DP_LAT cycles later back to it
//   through a registered response stage. A pause/drain control stops
//   issuing and reports when the pipeline is empty; saturating per-
//   requester counters tally datapath errors.
// Ports:
//   clk, reset                 : clock, synchronous active-high reset
//   reqN_valid/data/rot/ready  : requester N job handshake (N = 0, 1)
//   dp_valid/dp_data_in/dp_rot : combinational issue to the datapath
//   dp_data_out, dp_error      : datapath result, DP_LAT cycles after issue
//   rsp_valid/id/data/error    : registered response, no backpressure
//   pause_req, pause_ack       : stop issuing / paused with pipeline empty
//   err_cnt0, err_cnt1         : saturating error counts per requester
// ---------------------------------------------------------------------------
module rot_arbiter
   import rot_arbiter_pkg::*;
#(
   parameter int BUS_SIZE  = 32,
   parameter int WORD_SIZE = 4,
   parameter int ROT_W     = 3,
   parameter int DP_LAT    = 1,
   parameter int ERR_W     = 8
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                req0_valid,
   input  logic [BUS_SIZE-1:0] req0_data,
   input  logic [ROT_W-1:0]    req0_rot,
   output logic                req0_ready,
   input  logic                req1_valid,
   input  logic [BUS_SIZE-1:0] req1_data,
   input  logic [ROT_W-1:0]    req1_rot,
   output logic                req1_ready,
   output logic                dp_valid,
   output logic [BUS_SIZE-1:0] dp_data_in,
   output logic [ROT_W-1:0]    dp_rot,
   input  logic [BUS_SIZE-1:0] dp_data_out,
   input  logic                dp_error,
   output logic                rsp_valid,
   output logic                rsp_id,
   output logic [BUS_SIZE-1:0] rsp_data,
   output logic                rsp_error,
   input  logic                pause_req,
   output logic                pause_ack,
   output logic [ERR_W-1:0]    err_cnt0,
   output logic [ERR_W-1:0]    err_cnt1
);

   localparam int WORD_NUM  = word_num(BUS_SIZE, WORD_SIZE);
   localparam int ROT_W_CHK = clog2_int(WORD_NUM);
   localparam logic [ERR_W-1:0] ERR_MAX = '1;

   generate
      if (ROT_W != ROT_W_CHK || DP_LAT < 1 || DP_LAT > 8) begin : g_param_err
         $error("rot_arbiter: ROT_W must be clog2(BUS_SIZE/WORD_SIZE), DP_LAT 1..8");
      end
   endgenerate

   arb_state_t state_reg, state_next;
   logic [1:0] grant;
   logic       arb_en;
   logic       issue_id;
   logic [DP_LAT-1:0] tag_valid_reg;
   logic [DP_LAT-1:0] tag_id_reg;
   logic       tail_valid;
   logic       tail_id;
   logic       pipe_busy;
   logic       pause_ack_reg;
   logic       rsp_valid_reg, rsp_id_reg, rsp_error_reg;
   logic [BUS_SIZE-1:0] rsp_data_reg;
   logic [ERR_W-1:0]    err_cnt0_reg, err_cnt1_reg;

   // Grants are masked during reset so every output reads 0 while it is held,
   // and the cycle that raises pause_req already issues nothing.
   assign arb_en = !reset && (state_reg == ST_RUN) && !pause_req;

   rr_arb2 u_arb (
      .clk   (clk),
      .reset (reset),
      .en    (arb_en),
      .req   ({req1_valid, req0_valid}),
      .grant (grant)
   );

   assign req0_ready = grant[0];
   assign req1_ready = grant[1];
   assign dp_valid   = |grant;

   always_comb begin
      dp_data_in = '0;
      dp_rot     = '0;
      issue_id   = 1'b0;
      if (grant[0]) begin
         dp_data_in = req0_data;
         dp_rot     = req0_rot;
      end else if (grant[1]) begin
         dp_data_in = req1_data;
         dp_rot     = req1_rot;
         issue_id   = 1'b1;
      end
   end

   // Tag pipeline: stage DP_LAT-1 lines up with dp_data_out/dp_error.
   generate
      if (DP_LAT == 1) begin : g_tag_one
         always_ff @(posedge clk) begin
            if (reset) begin
               tag_valid_reg <= '0;
               tag_id_reg    <= '0;
            end else begin
               tag_valid_reg <= dp_valid;
               tag_id_reg    <= issue_id;
            end
         end
      end else begin : g_tag_multi
         always_ff @(posedge clk) begin
            if (reset) begin
               tag_valid_reg <= '0;
               tag_id_reg    <= '0;
            end else begin
               tag_valid_reg <= {tag_valid_reg[DP_LAT-2:0], dp_valid};
               tag_id_reg    <= {tag_id_reg[DP_LAT-2:0], issue_id};
            end
         end
      end
   endgenerate

   assign tail_valid = tag_valid_reg[DP_LAT-1];
   assign tail_id    = tag_id_reg[DP_LAT-1];
   assign pipe_busy  = (|tag_valid_reg) || rsp_valid_reg;

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_RUN:    if (pause_req) state_next = ST_DRAIN;
         ST_DRAIN: begin
            if (!pause_req) begin
               state_next = ST_RUN;
            end else if (!pipe_busy) begin
               state_next = ST_PAUSED;
            end
         end
         ST_PAUSED: if (!pause_req) state_next = ST_RUN;
         default:   state_next = ST_RUN;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg     <= ST_RUN;
         pause_ack_reg <= 1'b0;
         rsp_valid_reg <= 1'b0;
         rsp_id_reg    <= 1'b0;
         rsp_data_reg  <= '0;
         rsp_error_reg <= 1'b0;
         err_cnt0_reg  <= '0;
         err_cnt1_reg  <= '0;
      end else begin
         state_reg     <= state_next;
         pause_ack_reg <= (state_next == ST_PAUSED);
         rsp_valid_reg <= tail_valid;
         // Payload fields hold between responses; a stray dp_error with no
         // tag at the tail never reaches the response or the counters.
         if (tail_valid) begin
            rsp_id_reg    <= tail_id;
            rsp_data_reg  <= dp_data_out;
            rsp_error_reg <= dp_error;
            if (dp_error && !tail_id && err_cnt0_reg != ERR_MAX) begin
               err_cnt0_reg <= err_cnt0_reg + 1'b1;
            end
            if (dp_error && tail_id && err_cnt1_reg != ERR_MAX) begin
               err_cnt1_reg <= err_cnt1_reg + 1'b1;
            end
         end
      end
   end

   assign pause_ack = pause_ack_reg;
   assign rsp_valid = rsp_valid_reg;
   assign rsp_id    = rsp_id_reg;
   assign rsp_data  = rsp_data_reg;
   assign rsp_error = rsp_error_reg;
   assign err_cnt0  = err_cnt0_reg;
   assign err_cnt1  = err_cnt1_reg;

endmodule

// File: tb/tb_rot_arbiter.sv
// ---------------------------------------------------------------------------
// tb_rot_arbiter
//   Two instances share the requester/pause/reset stimulus: dut_a with
//   DP_LAT=1 and dut_b with DP_LAT=3, each fed by its own model datapath
//   (rotate left by rot words; error flag = err_mode & payload MSB, or the
//   stray_err level when no job sits at the datapath output).
//   Expected grants come from a bench pointer; expected responses are pushed
//   per instance with their due cycle and popped by a per-cycle monitor.
// ---------------------------------------------------------------------------
module tb_rot_arbiter;

   localparam int LAT_A = 1;
   localparam int LAT_B = 3;

   typedef struct {
      int          due;
      logic        id;
      logic [31:0] data;
      logic        err;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset, pause_req;
   logic        req0_valid, req1_valid;
   logic [31:0] req0_data, req1_data;
   logic [2:0]  req0_rot, req1_rot;

   logic        a_req0_ready, a_req1_ready, a_dp_valid, a_dp_error;
   logic        a_rsp_valid, a_rsp_id, a_rsp_error, a_pause_ack;
   logic [31:0] a_dp_data_in, a_dp_data_out, a_rsp_data;
   logic [2:0]  a_dp_rot;
   logic [7:0]  a_err_cnt0, a_err_cnt1;

   logic        b_req0_ready, b_req1_ready, b_dp_valid, b_dp_error;
   logic        b_rsp_valid, b_rsp_id, b_rsp_error, b_pause_ack;
   logic [31:0] b_dp_data_in, b_dp_data_out, b_rsp_data;
   logic [2:0]  b_dp_rot;
   logic [7:0]  b_err_cnt0, b_err_cnt1;

   int   total = 0;
   int   bad   = 0;
   int   cyc   = 0;
   logic ptr_m = 1'b0;
   logic err_mode = 1'b0;
   logic stray_err = 1'b0;
   exp_t q_a[$];
   exp_t q_b[$];
   exp_t ea, eb;

   rot_arbiter #(.BUS_SIZE(32), .WORD_SIZE(4), .ROT_W(3), .DP_LAT(LAT_A), .ERR_W(8)) dut_a (
      .clk(clk), .reset(reset),
      .req0_valid(req0_valid), .req0_data(req0_data), .req0_rot(req0_rot), .req0_ready(a_req0_ready),
      .req1_valid(req1_valid), .req1_data(req1_data), .req1_rot(req1_rot), .req1_ready(a_req1_ready),
      .dp_valid(a_dp_valid), .dp_data_in(a_dp_data_in), .dp_rot(a_dp_rot),
      .dp_data_out(a_dp_data_out), .dp_error(a_dp_error),
      .rsp_valid(a_rsp_valid), .rsp_id(a_rsp_id), .rsp_data(a_rsp_data), .rsp_error(a_rsp_error),
      .pause_req(pause_req), .pause_ack(a_pause_ack),
      .err_cnt0(a_err_cnt0), .err_cnt1(a_err_cnt1)
   );

   rot_arbiter #(.BUS_SIZE(32), .WORD_SIZE(4), .ROT_W(3), .DP_LAT(LAT_B), .ERR_W(8)) dut_b (
      .clk(clk), .reset(reset),
      .req0_valid(req0_valid), .req0_data(req0_data), .req0_rot(req0_rot), .req0_ready(b_req0_ready),
      .req1_valid(req1_valid), .req1_data(req1_data), .req1_rot(req1_rot), .req1_ready(b_req1_ready),
      .dp_valid(b_dp_valid), .dp_data_in(b_dp_data_in), .dp_rot(b_dp_rot),
      .dp_data_out(b_dp_data_out), .dp_error(b_dp_error),
      .rsp_valid(b_rsp_valid), .rsp_id(b_rsp_id), .rsp_data(b_rsp_data), .rsp_error(b_rsp_error),
      .pause_req(pause_req), .pause_ack(b_pause_ack),
      .err_cnt0(b_err_cnt0), .err_cnt1(b_err_cnt1)
   );

   function automatic logic [31:0] rotl(input logic [31:0] d, input logic [2:0] r);
      logic [63:0] t;
      t = {d, d} << (4 * r);
      return t[63:32];
   endfunction

   // Model datapaths: {valid, error, data} delay lines.
   logic [33:0] pa [LAT_A];
   logic [33:0] pb [LAT_B];
   always @(posedge clk) begin
      pa[0] <= {a_dp_valid, err_mode & a_dp_data_in[31], rotl(a_dp_data_in, a_dp_rot)};
      pb[0] <= {b_dp_valid, err_mode & b_dp_data_in[31], rotl(b_dp_data_in, b_dp_rot)};
      for (int i = 1; i < LAT_B; i++) pb[i] <= pb[i-1];
   end
   assign a_dp_data_out = pa[LAT_A-1][31:0];
   assign a_dp_error    = pa[LAT_A-1][33] ? pa[LAT_A-1][32] : stray_err;
   assign b_dp_data_out = pb[LAT_B-1][31:0];
   assign b_dp_error    = pb[LAT_B-1][33] ? pb[LAT_B-1][32] : stray_err;

   always @(posedge clk) cyc <= cyc + 1;

   // Response monitor: each cycle either the head entry is due, or no
   // response may appear.
   always @(posedge clk) begin
      #1;
      total++;
      if (q_a.size() > 0 && q_a[0].due == cyc) begin
         ea = q_a.pop_front();
         if (a_rsp_valid !== 1'b1 || a_rsp_id !== ea.id || a_rsp_data !== ea.data || a_rsp_error !== ea.err) begin
            bad++;
            $display("FAIL rsp_a cyc=%0d got v=%b id=%b data=%h err=%b want v=1 id=%b data=%h err=%b",
                     cyc, a_rsp_valid, a_rsp_id, a_rsp_data, a_rsp_error, ea.id, ea.data, ea.err);
         end
      end else if (a_rsp_valid !== 1'b0) begin
         bad++;
         $display("FAIL rsp_a_unexpected cyc=%0d got v=%b want v=0", cyc, a_rsp_valid);
      end
      total++;
      if (q_b.size() > 0 && q_b[0].due == cyc) begin
         eb = q_b.pop_front();
         if (b_rsp_valid !== 1'b1 || b_rsp_id !== eb.id || b_rsp_data !== eb.data || b_rsp_error !== eb.err) begin
            bad++;
            $display("FAIL rsp_b cyc=%0d got v=%b id=%b data=%h err=%b want v=1 id=%b data=%h err=%b",
                     cyc, b_rsp_valid, b_rsp_id, b_rsp_data, b_rsp_error, eb.id, eb.data, eb.err);
         end
      end else if (b_rsp_valid !== 1'b0) begin
         bad++;
         $display("FAIL rsp_b_unexpected cyc=%0d got v=%b want v=0", cyc, b_rsp_valid);
      end
   end

   // One cycle of stimulus: drive at the falling edge, check the issue side
   // against the bench arbiter, push expected responses for granted jobs.
   task automatic drive(input logic v0, input logic [31:0] d0, input logic [2:0] r0,
                        input logic v1, input logic [31:0] d1, input logic [2:0] r1,
                        input logic p, input logic rst, input logic en);
      logic g0, g1;
      logic [31:0] ed;
      logic [2:0] er;
      exp_t e;
      @(negedge clk);
      reset = rst; pause_req = p;
      req0_valid = v0; req0_data = d0; req0_rot = r0;
      req1_valid = v1; req1_data = d1; req1_rot = r1;
      #1;
      g0 = 1'b0; g1 = 1'b0;
      if (en) begin
         if (v0 && v1) begin
            g0 = !ptr_m; g1 = ptr_m;
         end else begin
            g0 = v0; g1 = v1;
         end
      end
      ed = g0 ? d0 : (g1 ? d1 : 32'h0);
      er = g0 ? r0 : (g1 ? r1 : 3'h0);
      total++;
      if ({a_req0_ready, a_req1_ready, a_dp_valid, a_dp_data_in, a_dp_rot} !== {g0, g1, g0 | g1, ed, er}) begin
         bad++;
         $display("FAIL issue_a cyc=%0d got rdy=%b%b v=%b data=%h rot=%0d want rdy=%b%b v=%b data=%h rot=%0d",
                  cyc, a_req1_ready, a_req0_ready, a_dp_valid, a_dp_data_in, a_dp_rot, g1, g0, g0 | g1, ed, er);
      end
      total++;
      if ({b_req0_ready, b_req1_ready, b_dp_valid, b_dp_data_in, b_dp_rot} !== {g0, g1, g0 | g1, ed, er}) begin
         bad++;
         $display("FAIL issue_b cyc=%0d got rdy=%b%b v=%b data=%h rot=%0d want rdy=%b%b v=%b data=%h rot=%0d",
                  cyc, b_req1_ready, b_req0_ready, b_dp_valid, b_dp_data_in, b_dp_rot, g1, g0, g0 | g1, ed, er);
      end
      if (rst) begin
         ptr_m = 1'b0;
         q_a.delete();
         q_b.delete();
      end else if (g0 || g1) begin
         e.id   = g1;
         e.data = rotl(ed, er);
         e.err  = err_mode & ed[31];
         e.due  = cyc + LAT_A + 1;
         q_a.push_back(e);
         e.due  = cyc + LAT_B + 1;
         q_b.push_back(e);
         ptr_m  = g0;
      end
   endtask

   task automatic idle(input int n);
      repeat (n) drive(1'b0, 32'h0, 3'h0, 1'b0, 32'h0, 3'h0, 1'b0, 1'b0, 1'b1);
   endtask

   task automatic both_valid(input logic p, input logic rst, input logic en);
      logic [31:0] r0, r1;
      r0 = $urandom(); r1 = $urandom();
      drive(1'b1, r0, r0[2:0], 1'b1, r1, r1[6:4], p, rst, en);
   endtask

   task automatic test_reset;
      repeat (3) both_valid(1'b0, 1'b1, 1'b0);
      total++;
      if ({a_req0_ready, a_req1_ready, a_dp_valid, a_dp_data_in, a_dp_rot, a_rsp_valid, a_rsp_id, a_rsp_data,
           a_rsp_error, a_pause_ack, a_err_cnt0, a_err_cnt1} !== '0) begin
         bad++;
         $display("FAIL reset_outputs_a got rdy=%b%b dpv=%b rspv=%b data=%h ack=%b cnt=%0d/%0d want all 0",
                  a_req1_ready, a_req0_ready, a_dp_valid, a_rsp_valid, a_rsp_data, a_pause_ack, a_err_cnt0, a_err_cnt1);
      end
      total++;
      if ({b_req0_ready, b_req1_ready, b_dp_valid, b_dp_data_in, b_dp_rot, b_rsp_valid, b_rsp_id, b_rsp_data,
           b_rsp_error, b_pause_ack, b_err_cnt0, b_err_cnt1} !== '0) begin
         bad++;
         $display("FAIL reset_outputs_b got rdy=%b%b dpv=%b rspv=%b data=%h ack=%b cnt=%0d/%0d want all 0",
                  b_req1_ready, b_req0_ready, b_dp_valid, b_rsp_valid, b_rsp_data, b_pause_ack, b_err_cnt0, b_err_cnt1);
      end
      idle(1);
   endtask

   task automatic test_single;
      drive(1'b1, 32'h12345678, 3'd1, 1'b0, 32'h0, 3'h0, 1'b0, 1'b0, 1'b1);
      idle(1);
      total++;
      if (a_rsp_valid !== 1'b0) begin
         bad++; $display("FAIL single_early got rsp_valid=%b want 0", a_rsp_valid);
      end
      idle(1);
      total++;
      if (a_rsp_valid !== 1'b1 || a_rsp_id !== 1'b0 || a_rsp_data !== 32'h23456781) begin
         bad++;
         $display("FAIL single_rsp got v=%b id=%b data=%h want v=1 id=0 data=23456781", a_rsp_valid, a_rsp_id, a_rsp_data);
      end
      idle(3);
      total++;
      if (a_rsp_valid !== 1'b0 || a_rsp_data !== 32'h23456781 || b_rsp_data !== 32'h23456781) begin
         bad++;
         $display("FAIL single_hold got v=%b a=%h b=%h want v=0 a=b=23456781", a_rsp_valid, a_rsp_data, b_rsp_data);
      end
   endtask

   task automatic test_alternate;
      both_valid(1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 6; i++) begin
         both_valid(1'b0, 1'b0, 1'b1);
         total++;
         if (a_req1_ready !== i[0] || a_req0_ready !== !i[0]) begin
            bad++;
            $display("FAIL alternate_grant%0d got rdy=%b%b want rdy=%b%b", i, a_req1_ready, a_req0_ready, i[0], !i[0]);
         end
      end
      idle(6);
   endtask

   task automatic test_only_req1;
      logic [31:0] r;
      for (int i = 0; i < 3; i++) begin
         r = $urandom();
         drive(1'b0, 32'h0, 3'h0, 1'b1, r, r[2:0], 1'b0, 1'b0, 1'b1);
      end
      both_valid(1'b0, 1'b0, 1'b1);
      total++;
      if (a_req0_ready !== 1'b1 || b_req0_ready !== 1'b1) begin
         bad++; $display("FAIL req1_then_contend got a=%b b=%b want req0 granted", a_req0_ready, b_req0_ready);
      end
      both_valid(1'b0, 1'b0, 1'b1);
      idle(6);
   endtask

   task automatic test_pause;
      int  n;
      bool_loop: begin end
      both_valid(1'b0, 1'b0, 1'b1);
      both_valid(1'b0, 1'b0, 1'b1);
      n = 0;
      while (n < 40 && !(a_pause_ack === 1'b1 && b_pause_ack === 1'b1)) begin
         both_valid(1'b1, 1'b0, 1'b0);
         total++;
         if ((a_pause_ack && (q_a.size() != 0 || a_rsp_valid)) || (b_pause_ack && (q_b.size() != 0 || b_rsp_valid))) begin
            bad++;
            $display("FAIL pause_ack_early got ack=%b/%b pending=%0d/%0d want ack only when drained",
                     a_pause_ack, b_pause_ack, q_a.size(), q_b.size());
         end
         n++;
      end
      total++;
      if (a_pause_ack !== 1'b1 || b_pause_ack !== 1'b1) begin
         bad++; $display("FAIL pause_ack_timeout got ack=%b/%b want 1/1", a_pause_ack, b_pause_ack);
      end
      both_valid(1'b0, 1'b0, 1'b0);
      both_valid(1'b0, 1'b0, 1'b1);
      total++;
      if (b_pause_ack !== 1'b0 || b_dp_valid !== 1'b1) begin
         bad++; $display("FAIL pause_resume got ack=%b dp_valid=%b want ack=0 dp_valid=1", b_pause_ack, b_dp_valid);
      end
      idle(6);
   endtask

   task automatic test_errors;
      logic [31:0] r0, r1;
      err_mode = 1'b1;
      for (int i = 0; i < 520; i++) begin
         r0 = $urandom(); r1 = $urandom();
         drive(1'b1, {1'b0, r0[30:0]}, r0[2:0], 1'b1, {1'b1, r1[30:0]}, r1[2:0], 1'b0, 1'b0, 1'b1);
      end
      idle(6);
      err_mode = 1'b0;
      total++;
      if (a_err_cnt1 !== 8'hFF || a_err_cnt0 !== 8'h00 || b_err_cnt1 !== 8'hFF || b_err_cnt0 !== 8'h00) begin
         bad++;
         $display("FAIL err_saturate got a=%0d/%0d b=%0d/%0d want cnt0=0 cnt1=255",
                  a_err_cnt0, a_err_cnt1, b_err_cnt0, b_err_cnt1);
      end
      stray_err = 1'b1;
      idle(4);
      stray_err = 1'b0;
      idle(1);
      total++;
      if (a_err_cnt0 !== 8'h00 || b_err_cnt0 !== 8'h00 || a_err_cnt1 !== 8'hFF || b_err_cnt1 !== 8'hFF) begin
         bad++;
         $display("FAIL err_stray got a=%0d/%0d b=%0d/%0d want cnt0=0 cnt1=255",
                  a_err_cnt0, a_err_cnt1, b_err_cnt0, b_err_cnt1);
      end
   endtask

   task automatic test_reset_midflight;
      both_valid(1'b0, 1'b0, 1'b1);
      both_valid(1'b0, 1'b0, 1'b1);
      both_valid(1'b0, 1'b1, 1'b0);
      both_valid(1'b0, 1'b1, 1'b0);
      total++;
      if ({a_rsp_valid, a_rsp_data, a_rsp_error, a_pause_ack, a_err_cnt0, a_err_cnt1, a_dp_valid} !== '0 ||
          {b_rsp_valid, b_rsp_data, b_rsp_error, b_pause_ack, b_err_cnt0, b_err_cnt1, b_dp_valid} !== '0) begin
         bad++;
         $display("FAIL midreset_outputs got a v=%b cnt=%0d/%0d b v=%b cnt=%0d/%0d want all 0",
                  a_rsp_valid, a_err_cnt0, a_err_cnt1, b_rsp_valid, b_err_cnt0, b_err_cnt1);
      end
      idle(6);
      both_valid(1'b0, 1'b0, 1'b1);
      total++;
      if (a_req0_ready !== 1'b1 || b_req0_ready !== 1'b1) begin
         bad++; $display("FAIL midreset_pointer got a=%b b=%b want req0 granted", a_req0_ready, b_req0_ready);
      end
      idle(6);
   endtask

   initial begin
      reset = 1'b1; pause_req = 1'b0;
      req0_valid = 1'b0; req0_data = 32'h0; req0_rot = 3'h0;
      req1_valid = 1'b0; req1_data = 32'h0; req1_rot = 3'h0;
      test_reset();
      test_single();
      test_alternate();
      test_only_req1();
      test_pause();
      test_errors();
      test_reset_midflight();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
